line_cmd_sequencer: RTL

Initiator for the line drawer's start/done handshake. It buffers line commands (two endpoints plus colour) from an upstream producer in a small FIFO and issues them one at a time to the line drawer. For each command it holds `start` and stable endpoints until the drawer reports `done`, then releases. It sits between the command source (CPU, ROM walker or testbench) and `line_drawer_control`/`line_drawer_data`.

---
 rtl/line_cmd_sequencer_if.sv | 31 +++
 rtl/line_cmd_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/line_cmd_sequencer_if.sv
// line_cmd_sequencer_if: command-in / line-drawer-out bundle for line_cmd_sequencer.
//   cmd_valid/cmd_ready, cmd_x0..cmd_colour : upstream command handshake
//   start/done, x0..colour                  : line drawer request handshake
//   busy, lines_drawn, lines_dropped        : status
interface line_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_x1;
  logic [7:0]  cmd_y1;
  logic [2:0]  cmd_colour;
  logic        start;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [8:0]  x1;
  logic [7:0]  y1;
  logic [2:0]  colour;
  logic        done;
  logic        busy;
  logic [15:0] lines_drawn;
  logic [7:0]  lines_dropped;
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, done,
    output cmd_ready, start, x0, y0, x1, y1, colour, busy, lines_drawn, lines_dropped
  );
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, done,
    input  cmd_ready, start, x0, y0, x1, y1, colour, busy, lines_drawn, lines_dropped
  );
endinterface

// File: rtl/line_cmd_sequencer.sv
// line_cmd_sequencer: buffers line commands in a FIFO and issues them one at a time over start/done.
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : slave side of line_cmd_sequencer_if (command input, drawer output, status)
module line_cmd_sequencer #(
  parameter int         DEPTH = 4,
  parameter logic [8:0] XMAX  = 9'd159,
  parameter logic [7:0] YMAX  = 8'd119
) (
  input logic                  clk,
  input logic                  resetn,
  line_cmd_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  state_t        r_state;
  logic [36:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          r_start;
  logic [8:0]    r_x0, r_x1;
  logic [7:0]    r_y0, r_y1;
  logic [2:0]    r_colour;
  logic [15:0]   r_lines_drawn;
  logic [7:0]    r_lines_dropped;
  logic          w_push, w_pop, w_ok;
  logic [36:0]   w_head;
  assign bus.cmd_ready     = r_count != FULL;
  assign bus.busy          = r_state != IDLE || r_count != '0;
  assign bus.start         = r_start;
  assign bus.x0            = r_x0;
  assign bus.y0            = r_y0;
  assign bus.x1            = r_x1;
  assign bus.y1            = r_y1;
  assign bus.colour        = r_colour;
  assign bus.lines_drawn   = r_lines_drawn;
  assign bus.lines_dropped = r_lines_dropped;
  assign w_push = bus.cmd_valid && bus.cmd_ready;
  // Only IDLE consumes the head; in-range heads are issued, others are discarded.
  assign w_pop  = r_state == IDLE && r_count != '0;
  assign w_head = r_mem[r_rp];
  assign w_ok   = w_head[36:28] <= XMAX && w_head[19:11] <= XMAX &&
                  w_head[27:20] <= YMAX && w_head[10:3]  <= YMAX;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1, bus.cmd_colour};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state         <= IDLE;
      r_wp            <= '0;
      r_rp            <= '0;
      r_count         <= '0;
      r_start         <= 1'b0;
      r_x0            <= '0;
      r_y0            <= '0;
      r_x1            <= '0;
      r_y1            <= '0;
      r_colour        <= '0;
      r_lines_drawn   <= '0;
      r_lines_dropped <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      case (r_state)
        IDLE:
          if (w_pop) begin
            if (w_ok) begin
              {r_x0, r_y0, r_x1, r_y1, r_colour} <= w_head;
              r_start <= 1'b1;
              r_state <= ISSUE;
            end else if (r_lines_dropped != 8'hFF) begin
              r_lines_dropped <= r_lines_dropped + 8'd1;
            end
          end
        ISSUE:
          if (bus.done) begin
            r_start <= 1'b0;
            r_state <= RELEASE;
          end
        RELEASE:
          // The drawer must drop done before the line counts and the next one may start.
          if (!bus.done) begin
            if (r_lines_drawn != 16'hFFFF) r_lines_drawn <= r_lines_drawn + 16'd1;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
